uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Sits directly downstream of the UART receiver in uart_top and consumes its received bytes. Delineates frames of the form HEADER, LEN, LEN payload bytes, CSUM, and buffers the payload internally. A payload is released to the downstream stream interface only after its checksum verifies. Corrupt, oversize or stalled frames are reported and discarded.

Parameters:
CLOCK_FREQ, 50_000_000, system clock in Hz (timeout scaling only)
BAUD_RATE, 115_200, line baud rate (timeout scaling only)
HEADER, 8'h5A, frame start byte
MAX_LEN, 16, maximum payload bytes; sizes the buffer; 1..255
TIMEOUT_BITS, 20, inter-byte timeout in bit times

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe: rx_data valid
rx_err  in  1  parity/framing error, qualified by rx_valid
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts byte
out_last  out  1  final payload byte of frame
pkt_ok  out  1  one-cycle pulse: frame accepted
pkt_err  out  1  one-cycle pulse: frame discarded
err_code  out  2  0=CSUM 1=LEN 2=RX 3=TIMEOUT; valid with pkt_err, holds until the next pkt_err
drop_cnt  out  8  saturating count of bytes ignored in DRAIN
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE; all outputs 0.
  - Buffer contents don't-care.
- Clocking: everything sampled on rising clk. rx bytes only counted on rx_valid=1.
- Running sum: 8-bit, mod 256, over LEN and all payload bytes. Frame accepted iff CSUM == sum.
- IDLE:
  - rx_valid & !rx_err & rx_data==HEADER -> LEN.
  - Any other byte, including rx_err bytes, is ignored silently.
- LEN:
  - LEN > MAX_LEN -> pkt_err, code 1, -> IDLE.
  - LEN == 0 -> CSUM.
  - Otherwise store LEN, clear byte index, -> PAYLOAD.
- PAYLOAD: each byte is written to buf[idx] and added to the sum. After the LENth byte -> CSUM.
- CSUM:
  - Match -> pkt_ok. Then LEN>0 -> DRAIN; LEN==0 -> IDLE with no stream output.
  - Mismatch -> pkt_err, code 0, -> IDLE.
- Latency: pkt_ok/pkt_err are registered and pulse the cycle after the deciding rx_valid. For LEN errors, the deciding byte is the LEN byte itself.
- DRAIN:
  - out_valid rises in the same cycle as pkt_ok, with out_data=buf[0].
  - A byte transfers on out_valid & out_ready. The next byte is presented the following cycle, so the stream sustains one byte per cycle.
  - out_data/out_last are stable while out_valid & !out_ready.
  - out_last=1 only with buf[LEN-1].
  - The transfer of the last byte -> IDLE; out_valid falls the next cycle.
- rx during DRAIN: every rx_valid is ignored and drop_cnt increments, saturating at 255. This includes a HEADER byte; a new frame cannot start until IDLE.
- rx_err=1 with rx_valid in LEN, PAYLOAD or CSUM -> pkt_err, code 2, -> IDLE.
- A single rx_valid cycle produces at most one pkt_ok or pkt_err.
- Parser decisions are unaffected by out_ready.
- busy=1 in LEN, PAYLOAD, CSUM and DRAIN.

Optional Feature:
Macro: UART_FRAME_PARSER_TIMEOUT_EN
- Defined:
  - Counter limit = TIMEOUT_BITS*(CLOCK_FREQ/BAUD_RATE) cycles, integer division.
  - The counter clears on every accepted rx_valid in LEN, PAYLOAD or CSUM.
  - Reaching the limit while in one of those states -> pkt_err, code 3, -> IDLE.
  - The counter does not run in IDLE or DRAIN.
  - If an rx_valid arrives in the same cycle as expiry, the byte wins.
- Undefined: no counter logic is present; a stalled frame waits indefinitely. err_code 3 is never produced.

Test Plan:
- Good frame: rx 5A 03 11 22 33 69 -> pkt_ok one cycle after the 69 strobe. With out_ready=1, out_data 11,22,33 appear on consecutive cycles; out_last with 33 only. err_code is untouched.
- Bad checksum: rx 5A 03 11 22 33 68 -> pkt_err, err_code=0, out_valid never asserted. Then rx 5A 00 00 -> pkt_ok, no stream output.
- Oversize and junk:
  - rx 00 FF 5A 11 (MAX_LEN=16) -> the 00 and FF bytes are ignored; pkt_err, code 1, the cycle after the 11 strobe.
  - Follow with 5A 01 AA AB -> pkt_ok, out_data AA with out_last.
- Backpressure and drops:
  - Good 3-byte frame with out_ready toggling 0/1 each cycle -> each byte held stable until accepted; exactly 3 transfers.
  - Two rx bytes during DRAIN -> drop_cnt=2.
- Receiver error: rx 5A 02 11 with rx_err=1 on the 11 strobe -> pkt_err, code 2. The buffer is not released, and a following good frame parses normally.
- Timeout and reset (macro defined, defaults, limit=20*434=8680 cycles):
  - rx 5A 02 then silence -> pkt_err, code 3, exactly 8680 cycles after the 02 strobe.
  - Separately, assert rst_n=0 mid-DRAIN -> out_valid=0 and busy=0 immediately, drop_cnt=0.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Frame delineator behind the UART receiver: HEADER, LEN, payload, CSUM; payload released only on checksum match.
// Optional inter-byte timeout is enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
    parameter int         CLOCK_FREQ   = 50_000_000,
    parameter int         BAUD_RATE    = 115_200,
    parameter logic [7:0] HEADER       = 8'h5A,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << IDX_W;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] idx;
    logic [7:0] rd_idx;
    logic [7:0] sum;
    logic [7:0] pbuf [DEPTH];
    logic       buf_we;
    logic       in_frame;
    logic       tmo_hit;

    generate
        if (MAX_LEN < 1 || MAX_LEN > 255 || BAUD_RATE < 1 || CLOCK_FREQ < BAUD_RATE || TIMEOUT_BITS < 1) begin : g_bad_cfg
            $error("uart_frame_parser: invalid parameter set");
        end
    endgenerate

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign busy     = (state != S_IDLE);
    assign buf_we   = (state == S_PAYLOAD) && rx_valid && !rx_err;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int TMO_LIMIT = TIMEOUT_BITS * (CLOCK_FREQ / BAUD_RATE);
    logic [31:0] tmo_cnt;

    // Counts silent cycles inside a frame; any received byte restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_frame || rx_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_hit = in_frame && (tmo_cnt == 32'(TMO_LIMIT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Payload storage carries no reset; its contents only matter after a full frame has been written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pbuf[idx[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            sum       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
            drop_cnt  <= '0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid && !rx_err && rx_data == HEADER) begin
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd2;
                            state    <= S_IDLE;
                        end else if (rx_data > MAX_LEN_B) begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd1;
                            state    <= S_IDLE;
                        end else begin
                            len   <= rx_data;
                            sum   <= rx_data;
                            idx   <= '0;
                            state <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end

                S_PAYLOAD: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd2;
                            state    <= S_IDLE;
                        end else begin
                            sum <= sum + rx_data;
                            if (idx == len - 8'd1) begin
                                state <= S_CSUM;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end

                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd2;
                            state    <= S_IDLE;
                        end else if (rx_data == sum) begin
                            pkt_ok <= 1'b1;
                            if (len != 8'd0) begin
                                // First byte is presented together with the pkt_ok pulse.
                                state     <= S_DRAIN;
                                out_valid <= 1'b1;
                                out_data  <= pbuf[0];
                                out_last  <= (len == 8'd1);
                                rd_idx    <= 8'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd0;
                            state    <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= 2'd3;
                        state    <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (rx_valid && drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            out_data <= pbuf[rd_idx[IDX_W-1:0]];
                            out_last <= (rd_idx == len - 8'd1);
                            rd_idx   <= rd_idx + 8'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: table of frames plus hand sequences for backpressure, drops, reset and timeout.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;
    logic       busy;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .HEADER (8'h5A),
        .MAX_LEN(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .err_code (err_code),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    typedef struct packed {
        logic [159:0] b;
        int           n;
        int           err_at;
        logic         exp_ok;
        logic         exp_err;
        logic [1:0]   exp_code;
        int           exp_nout;
        int           out_start;
    } vec_t;

    vec_t vecs [12];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tot_ok = 0;
    int tot_err = 0;
    int pulse_cyc = -1;
    logic [7:0] out_q [$];
    logic       last_q [$];
    int         ocyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pkt_ok) begin
            tot_ok    <= tot_ok + 1;
            pulse_cyc <= cyc;
        end
        if (pkt_err) begin
            tot_err   <= tot_err + 1;
            pulse_cyc <= cyc;
        end
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
            ocyc_q.push_back(cyc);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [159:0] b, input int n, input int err_at, input logic ok,
                                input logic err, input logic [1:0] code, input int nout, input int start);
        vec_t v;
        v.b = b; v.n = n; v.err_at = err_at; v.exp_ok = ok; v.exp_err = err;
        v.exp_code = code; v.exp_nout = nout; v.out_start = start;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [159:0] b, input int n, input int i);
        return b[8*(n-1-i) +: 8];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_err   = e;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk(name, 32'(busy), 0);
    endtask

    int bo, be, bn, sc, ngot;
    logic pv, pr, pl, saw;
    logic [7:0] pd;

    initial begin
        vecs[0]  = mk(160'({8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6, -1, 1, 0, 2'd0, 3, 2);
        vecs[1]  = mk(160'({8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}), 6, -1, 0, 1, 2'd0, 0, 2);
        vecs[2]  = mk(160'({8'h5A, 8'h00, 8'h00}), 3, -1, 1, 0, 2'd0, 0, 2);
        vecs[3]  = mk(160'({8'h00, 8'hFF, 8'h5A, 8'h11}), 4, -1, 0, 1, 2'd1, 0, 4);
        vecs[4]  = mk(160'({8'h5A, 8'h01, 8'hAA, 8'hAB}), 4, -1, 1, 0, 2'd1, 1, 2);
        vecs[5]  = mk(160'({8'h5A, 8'h02, 8'h11}), 3, 2, 0, 1, 2'd2, 0, 2);
        vecs[6]  = mk(160'({8'h5A, 8'h02, 8'h01, 8'h02, 8'h05}), 5, -1, 1, 0, 2'd2, 2, 2);
        vecs[7]  = mk(160'({8'h5A, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h88}), 19, -1, 1, 0, 2'd2, 16, 2);
        vecs[8]  = mk(160'({8'h5A, 8'h02, 8'hFF, 8'hFF, 8'h00}), 5, -1, 1, 0, 2'd2, 2, 2);
        vecs[9]  = mk(160'({8'h5A, 8'h5A, 8'h01, 8'hAA, 8'hAB}), 5, 0, 1, 0, 2'd2, 1, 3);
        vecs[10] = mk(160'({8'h5A, 8'h01, 8'hAA, 8'hAC}), 4, -1, 0, 1, 2'd0, 0, 2);
        vecs[11] = mk(160'({8'h5A, 8'h01, 8'hAA, 8'hAB}), 4, 3, 0, 1, 2'd2, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pkt_ok", 32'(pkt_ok), 0);
        chk("rst pkt_err", 32'(pkt_err), 0);
        chk("rst err_code", 32'(err_code), 0);
        chk("rst drop_cnt", 32'(drop_cnt), 0);
        chk("rst out_last", 32'(out_last), 0);
        chk("rst out_data", 32'(out_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 12; k++) begin
            bo = tot_ok; be = tot_err; bn = out_q.size();
            for (int i = 0; i < vecs[k].n; i++) begin
                send(byte_of(vecs[k].b, vecs[k].n, i), (i == vecs[k].err_at));
            end
            sc = cyc;
            wait_idle($sformatf("v%0d idle", k));
            repeat (2) begin @(posedge clk); #1; end
            chk($sformatf("v%0d pkt_ok count", k), tot_ok - bo, 32'(vecs[k].exp_ok));
            chk($sformatf("v%0d pkt_err count", k), tot_err - be, 32'(vecs[k].exp_err));
            chk($sformatf("v%0d err_code", k), 32'(err_code), 32'(vecs[k].exp_code));
            chk($sformatf("v%0d pulse cycle", k), pulse_cyc, sc);
            ngot = out_q.size() - bn;
            chk($sformatf("v%0d out count", k), ngot, vecs[k].exp_nout);
            for (int j = 0; j < ngot && j < vecs[k].exp_nout; j++) begin
                chk($sformatf("v%0d out_data[%0d]", k, j), 32'(out_q[bn+j]),
                    32'(byte_of(vecs[k].b, vecs[k].n, vecs[k].out_start + j)));
                chk($sformatf("v%0d out_last[%0d]", k, j), 32'(last_q[bn+j]), 32'(j == vecs[k].exp_nout - 1));
                chk($sformatf("v%0d out cycle[%0d]", k, j), ocyc_q[bn+j], sc + j);
            end
        end

        // Backpressure with bytes dropped while draining
        out_ready = 1'b0;
        bo = tot_ok; bn = out_q.size();
        send(8'h5A, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h69, 0);
        chk("bp pkt_ok", 32'(pkt_ok), 1);
        chk("bp out_valid", 32'(out_valid), 1);
        chk("bp first data", 32'(out_data), 32'h11);
        chk("bp first last", 32'(out_last), 0);
        send(8'h5A, 0); send(8'h01, 0);
        chk("bp drop_cnt", 32'(drop_cnt), 2);
        chk("bp busy", 32'(busy), 1);
        chk("bp held data", 32'(out_data), 32'h11);
        chk("bp held valid", 32'(out_valid), 1);
        for (int i = 0; i < 40 && busy; i++) begin
            out_ready = ~out_ready;
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            @(posedge clk); #1;
            if (pv && !pr) begin
                chk("bp stable valid", 32'(out_valid), 1);
                chk("bp stable data", 32'(out_data), 32'(pd));
                chk("bp stable last", 32'(out_last), 32'(pl));
            end
        end
        chk("bp drained", 32'(busy), 0);
        repeat (2) begin @(posedge clk); #1; end
        ngot = out_q.size() - bn;
        chk("bp transfers", ngot, 3);
        if (ngot == 3) begin
            chk("bp byte0", 32'(out_q[bn]), 32'h11);
            chk("bp byte1", 32'(out_q[bn+1]), 32'h22);
            chk("bp byte2", 32'(out_q[bn+2]), 32'h33);
            chk("bp last0", 32'(last_q[bn]), 0);
            chk("bp last1", 32'(last_q[bn+1]), 0);
            chk("bp last2", 32'(last_q[bn+2]), 1);
        end
        chk("bp single pkt_ok", tot_ok - bo, 1);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        send(8'h5A, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hAB, 0);
        chk("mid busy", 32'(busy), 1);
        chk("mid out_valid", 32'(out_valid), 1);
        send(8'h33, 0);
        chk("mid drop_cnt", 32'(drop_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst drop_cnt", 32'(drop_cnt), 0);
        chk("arst err_code", 32'(err_code), 0);
        chk("arst out_last", 32'(out_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Stalled frame
        be = tot_err; bo = tot_ok;
        send(8'h5A, 0); send(8'h02, 0);
        sc = cyc;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        for (int i = 0; i < 9000; i++) begin
            if (pkt_err) break;
            @(posedge clk); #1;
        end
        chk("tmo pkt_err", 32'(pkt_err), 1);
        chk("tmo delay", cyc - sc, 8680);
        chk("tmo err_code", 32'(err_code), 3);
        chk("tmo busy", 32'(busy), 0);
`else
        saw = 1'b0;
        repeat (300) begin
            @(posedge clk); #1;
            if (pkt_err) saw = 1'b1;
        end
        chk("stall no pkt_err", 32'(saw), 0);
        chk("stall busy", 32'(busy), 1);
        chk("stall err_code", 32'(err_code), 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h05, 0);
        wait_idle("stall resume idle");
        repeat (2) begin @(posedge clk); #1; end
        chk("stall resume pkt_ok", tot_ok - bo, 1);
        chk("stall resume pkt_err", tot_err - be, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
